// File: rtl/dpram_dual_port_if.sv
// Per-port access bundle for dpram_dual_port: request fields in, registered read data and strobes out.
interface dpram_dual_port_if #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 2
);
    logic              en;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              rvalid;
    logic              err;

    modport master (output en, we, addr, wdata, input rdata, rvalid, err);
    modport slave  (input en, we, addr, wdata, output rdata, rvalid, err);
endinterface

// File: rtl/dpram_dual_port.sv
// Flop-based true dual-port RAM with collision policy, registered reads and a saturating collision counter.
// Optional macro DPRAM_BYPASS_EN forwards a cross-port same-address write to the reading port.
module dpram_dual_port #(
    parameter int DATA_W       = 4,
    parameter int DEPTH        = 4,
    parameter int COLLIDE_MODE = 0
) (
    input  logic             clk,
    input  logic             rst,
    dpram_dual_port_if.slave a_port,
    dpram_dual_port_if.slave b_port,
    output logic [7:0]       coll_cnt
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DATA_W-1:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
    logic              a_rvalid_q, a_rvalid_d, b_rvalid_q, b_rvalid_d;
    logic              a_err_q, a_err_d, b_err_q, b_err_d;
    logic [7:0]        coll_cnt_q, coll_cnt_d;

    logic [ADDR_W-1:0] a_addr, b_addr;
    logic [DATA_W-1:0] a_wdata, b_wdata, win_data;
    logic              a_ok, b_ok, a_wr, b_wr, a_rd, b_rd, coll;

    assign a_addr  = a_port.addr;
    assign b_addr  = b_port.addr;
    assign a_wdata = a_port.wdata;
    assign b_wdata = b_port.wdata;

    assign a_ok = a_port.en && ({1'b0, a_addr} < DEPTH_C);
    assign b_ok = b_port.en && ({1'b0, b_addr} < DEPTH_C);
    assign a_wr = a_ok && a_port.we;
    assign b_wr = b_ok && b_port.we;
    assign a_rd = a_ok && !a_port.we;
    assign b_rd = b_ok && !b_port.we;
    assign coll = a_wr && b_wr && (a_addr == b_addr);

    always_comb begin
        win_data = a_wdata;
        if (COLLIDE_MODE == 1) begin
            win_data = b_wdata;
        end else if (COLLIDE_MODE == 2) begin
            win_data = (a_wdata >= b_wdata) ? a_wdata : b_wdata;
        end
    end

    // Collision override comes last so it beats both individual port writes.
    always_comb begin
        mem_d = mem_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (rst) begin
                mem_d[i] = '0;
            end else begin
                if (a_wr && a_addr == ADDR_W'(i)) mem_d[i] = a_wdata;
                if (b_wr && b_addr == ADDR_W'(i)) mem_d[i] = b_wdata;
                if (coll && a_addr == ADDR_W'(i)) mem_d[i] = win_data;
            end
        end
    end

    always_comb begin
        a_rdata_d  = a_rdata_q;
        b_rdata_d  = b_rdata_q;
        a_rvalid_d = a_rd;
        b_rvalid_d = b_rd;
        a_err_d    = a_port.en && !a_ok;
        b_err_d    = b_port.en && !b_ok;
        coll_cnt_d = coll_cnt_q;
        if (a_rd) begin
            a_rdata_d = mem_q[a_addr];
`ifdef DPRAM_BYPASS_EN
            if (b_wr && b_addr == a_addr) a_rdata_d = b_wdata;
`endif
        end
        if (b_rd) begin
            b_rdata_d = mem_q[b_addr];
`ifdef DPRAM_BYPASS_EN
            if (a_wr && a_addr == b_addr) b_rdata_d = a_wdata;
`endif
        end
        if (coll && coll_cnt_q != 8'hFF) coll_cnt_d = coll_cnt_q + 8'd1;
        if (rst) begin
            a_rdata_d  = '0;
            b_rdata_d  = '0;
            a_rvalid_d = 1'b0;
            b_rvalid_d = 1'b0;
            a_err_d    = 1'b0;
            b_err_d    = 1'b0;
            coll_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        mem_q      <= mem_d;
        a_rdata_q  <= a_rdata_d;
        b_rdata_q  <= b_rdata_d;
        a_rvalid_q <= a_rvalid_d;
        b_rvalid_q <= b_rvalid_d;
        a_err_q    <= a_err_d;
        b_err_q    <= b_err_d;
        coll_cnt_q <= coll_cnt_d;
    end

    assign a_port.rdata  = a_rdata_q;
    assign a_port.rvalid = a_rvalid_q;
    assign a_port.err    = a_err_q;
    assign b_port.rdata  = b_rdata_q;
    assign b_port.rvalid = b_rvalid_q;
    assign b_port.err    = b_err_q;
    assign coll_cnt      = coll_cnt_q;
endmodule

// File: tb/tb_dpram_dual_port.sv
// Directed bench: three DEPTH=4 instances (collision modes 0/1/2) and one DEPTH=5 instance share stimulus.
module tb_dpram_dual_port;
    logic clk = 1'b0;
    logic rst;
    logic sel5;
    logic       a_en, a_we, b_en, b_we;
    logic [2:0] a_addr, b_addr;
    logic [3:0] a_wdata, b_wdata;

    logic [3:0][3:0] rd_a, rd_b;
    logic [3:0]      rv_a, rv_b, er_a, er_b;
    logic [3:0][7:0] cc;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    for (genvar m = 0; m < 3; m++) begin : g4
        dpram_dual_port_if #(.DATA_W(4), .ADDR_W(2)) ia ();
        dpram_dual_port_if #(.DATA_W(4), .ADDR_W(2)) ib ();
        assign ia.en = a_en & ~sel5;
        assign ia.we = a_we;
        assign ia.addr = a_addr[1:0];
        assign ia.wdata = a_wdata;
        assign ib.en = b_en & ~sel5;
        assign ib.we = b_we;
        assign ib.addr = b_addr[1:0];
        assign ib.wdata = b_wdata;
        dpram_dual_port #(.DATA_W(4), .DEPTH(4), .COLLIDE_MODE(m)) u_dut (
            .clk(clk), .rst(rst), .a_port(ia), .b_port(ib), .coll_cnt(cc[m]));
        assign rd_a[m] = ia.rdata;
        assign rv_a[m] = ia.rvalid;
        assign er_a[m] = ia.err;
        assign rd_b[m] = ib.rdata;
        assign rv_b[m] = ib.rvalid;
        assign er_b[m] = ib.err;
    end

    dpram_dual_port_if #(.DATA_W(4), .ADDR_W(3)) ia5 ();
    dpram_dual_port_if #(.DATA_W(4), .ADDR_W(3)) ib5 ();
    assign ia5.en = a_en & sel5;
    assign ia5.we = a_we;
    assign ia5.addr = a_addr;
    assign ia5.wdata = a_wdata;
    assign ib5.en = b_en & sel5;
    assign ib5.we = b_we;
    assign ib5.addr = b_addr;
    assign ib5.wdata = b_wdata;
    dpram_dual_port #(.DATA_W(4), .DEPTH(5), .COLLIDE_MODE(0)) u_dut5 (
        .clk(clk), .rst(rst), .a_port(ia5), .b_port(ib5), .coll_cnt(cc[3]));
    assign rd_a[3] = ia5.rdata;
    assign rv_a[3] = ia5.rvalid;
    assign er_a[3] = ia5.err;
    assign rd_b[3] = ib5.rdata;
    assign rv_b[3] = ib5.rvalid;
    assign er_b[3] = ib5.err;

    typedef struct {
        logic       ae, awe;
        logic [2:0] aa;
        logic [3:0] ad;
        logic       be, bwe;
        logic [2:0] ba;
        logic [3:0] bd;
        logic       arv;
        logic [3:0] ard;
        logic       brv;
        logic [3:0] brd;
    } vec_t;

    vec_t vt[8];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        a_en = 0; a_we = 0; a_addr = 0; a_wdata = 0;
        b_en = 0; b_we = 0; b_addr = 0; b_wdata = 0;
    endtask

    task automatic drive(input logic ae, input logic awe, input logic [2:0] aa, input logic [3:0] ad,
                         input logic be, input logic bwe, input logic [2:0] ba, input logic [3:0] bd);
        a_en = ae; a_we = awe; a_addr = aa; a_wdata = ad;
        b_en = be; b_we = bwe; b_addr = ba; b_wdata = bd;
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        step();
        rst = 0;
    endtask

    logic [3:0] exp_coll [3];
    logic [3:0] exp_byp;

    initial begin
        sel5 = 0;
        idle();
        rst = 1;
        step();
        step();
        rst = 0;

        for (int m = 0; m < 4; m++) begin
            chk($sformatf("rst_rdata_a%0d", m), rd_a[m], 0);
            chk($sformatf("rst_rdata_b%0d", m), rd_b[m], 0);
            chk($sformatf("rst_strobes%0d", m), {rv_a[m], rv_b[m], er_a[m], er_b[m]}, 0);
            chk($sformatf("rst_coll%0d", m), cc[m], 0);
        end

        vt[0] = '{1, 0, 3'd0, 4'h0, 1, 0, 3'd3, 4'h0, 1, 4'h0, 1, 4'h0};
        vt[1] = '{1, 0, 3'd1, 4'h0, 1, 0, 3'd2, 4'h0, 1, 4'h0, 1, 4'h0};
        vt[2] = '{1, 1, 3'd2, 4'h5, 0, 0, 3'd0, 4'h0, 0, 4'h0, 0, 4'h0};
        vt[3] = '{0, 0, 3'd0, 4'h0, 1, 0, 3'd2, 4'h0, 0, 4'h0, 1, 4'h5};
        vt[4] = '{1, 1, 3'd0, 4'h7, 1, 1, 3'd3, 4'hA, 0, 4'h0, 0, 4'h5};
        vt[5] = '{1, 0, 3'd3, 4'h0, 1, 0, 3'd0, 4'h0, 1, 4'hA, 1, 4'h7};
        vt[6] = '{0, 0, 3'd0, 4'h0, 0, 0, 3'd0, 4'h0, 0, 4'hA, 0, 4'h7};
        vt[7] = '{1, 0, 3'd2, 4'h0, 1, 0, 3'd2, 4'h0, 1, 4'h5, 1, 4'h5};

        for (int i = 0; i < 8; i++) begin
            drive(vt[i].ae, vt[i].awe, vt[i].aa, vt[i].ad, vt[i].be, vt[i].bwe, vt[i].ba, vt[i].bd);
            step();
            for (int m = 0; m < 3; m++) begin
                chk($sformatf("vec%0d_m%0d_a_rvalid", i, m), rv_a[m], vt[i].arv);
                chk($sformatf("vec%0d_m%0d_a_rdata", i, m), rd_a[m], vt[i].ard);
                chk($sformatf("vec%0d_m%0d_b_rvalid", i, m), rv_b[m], vt[i].brv);
                chk($sformatf("vec%0d_m%0d_b_rdata", i, m), rd_b[m], vt[i].brd);
                chk($sformatf("vec%0d_m%0d_err", i, m), {er_a[m], er_b[m]}, 0);
            end
        end
        idle();

        // Collision sweep: A=3, B=9 at address 1 across the three policies
        do_reset();
        exp_coll[0] = 4'h3; exp_coll[1] = 4'h9; exp_coll[2] = 4'h9;
        drive(1, 1, 3'd1, 4'h3, 1, 1, 3'd1, 4'h9);
        step();
        idle();
        for (int m = 0; m < 3; m++) chk($sformatf("coll_cnt1_m%0d", m), cc[m], 1);
        drive(1, 0, 3'd1, 4'h0, 0, 0, 3'd0, 4'h0);
        step();
        for (int m = 0; m < 3; m++) chk($sformatf("coll_store_m%0d", m), rd_a[m], exp_coll[m]);

        drive(1, 1, 3'd2, 4'h6, 1, 1, 3'd2, 4'h6);
        step();
        drive(1, 1, 3'd3, 4'hE, 1, 1, 3'd3, 4'h2);
        step();
        drive(0, 0, 3'd0, 4'h0, 1, 0, 3'd2, 4'h0);
        step();
        chk("coll_equal_m2", rd_b[2], 4'h6);
        chk("coll_cnt3_m2", cc[2], 3);
        exp_coll[0] = 4'hE; exp_coll[1] = 4'h2; exp_coll[2] = 4'hE;
        drive(0, 0, 3'd0, 4'h0, 1, 0, 3'd3, 4'h0);
        step();
        for (int m = 0; m < 3; m++) chk($sformatf("coll_a_larger_m%0d", m), rd_b[m], exp_coll[m]);
        idle();

        // Cross-port read of a word being written in the same cycle
        do_reset();
        drive(1, 1, 3'd0, 4'h7, 0, 0, 3'd0, 4'h0);
        step();
        drive(1, 1, 3'd0, 4'hC, 1, 0, 3'd0, 4'h0);
        step();
`ifdef DPRAM_BYPASS_EN
        exp_byp = 4'hC;
`else
        exp_byp = 4'h7;
`endif
        chk("xport_same_cycle", rd_b[0], exp_byp);
        chk("xport_same_cycle_rvalid", rv_b[0], 1);
        drive(0, 0, 3'd0, 4'h0, 1, 0, 3'd0, 4'h0);
        step();
        chk("xport_later_read", rd_b[0], 4'hC);
        idle();

        // Out-of-range accesses on the DEPTH=5 instance
        do_reset();
        sel5 = 1;
        drive(1, 1, 3'd4, 4'h1, 0, 0, 3'd0, 4'h0);
        step();
        drive(1, 1, 3'd6, 4'hF, 0, 0, 3'd0, 4'h0);
        step();
        chk("oor_wr_a_err", er_a[3], 1);
        chk("oor_wr_a_rvalid", rv_a[3], 0);
        idle();
        step();
        chk("oor_err_pulse", er_a[3], 0);
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 3'(i), 4'h0, 0, 0, 3'd0, 4'h0);
            step();
            chk($sformatf("oor_nochange_addr%0d", i), rd_a[3], (i == 4) ? 1 : 0);
        end
        drive(0, 0, 3'd0, 4'h0, 1, 0, 3'd4, 4'h0);
        step();
        drive(0, 0, 3'd0, 4'h0, 1, 0, 3'd7, 4'h0);
        step();
        chk("oor_rd_b_err", er_b[3], 1);
        chk("oor_rd_b_rvalid", rv_b[3], 0);
        chk("oor_rd_b_hold", rd_b[3], 1);
        idle();
        sel5 = 0;

        // Reset wins over a write and read presented in the same cycle
        drive(1, 1, 3'd3, 4'hF, 1, 0, 3'd0, 4'h0);
        rst = 1;
        step();
        rst = 0;
        idle();
        chk("rst_prio_rvalid_b", rv_b[0], 0);
        drive(1, 0, 3'd3, 4'h0, 0, 0, 3'd0, 4'h0);
        step();
        chk("rst_prio_read", rd_a[0], 0);
        chk("rst_prio_read_rvalid", rv_a[0], 1);
        idle();

        // Counter saturation
        drive(1, 1, 3'd1, 4'h2, 1, 1, 3'd1, 4'h4);
        for (int i = 0; i < 300; i++) step();
        idle();
        step();
        for (int m = 0; m < 3; m++) chk($sformatf("coll_sat_m%0d", m), cc[m], 255);
        chk("coll_sat_depth5_idle", cc[3], 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
